// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : bus_mem_responder
//  Description : Memory/peripheral responder for the cpu6502 external bus.
//                RAM, reset vector, outbound byte FIFO drained by a host,
//                and a one-byte inbound holding register read by the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_responder #(
    parameter int          RAM_AW    = 11,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [15:0] IO_BASE   = 16'hD000,
    parameter int          FIFO_AW   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  odata,
    input  logic        rw,
    input  logic        clk2,
    output logic [7:0]  idata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam logic [15:0] IO_FIFO = IO_BASE;
    localparam logic [15:0] IO_STAT = IO_BASE + 16'd1;
    localparam logic [15:0] IO_IN   = IO_BASE + 16'd2;

    logic               clk2_q;
    logic               rise;
    logic               fall;
    logic               in_ram;
    logic               wr_commit;
    logic               rd_commit;

    logic [7:0]         mem [2**RAM_AW];

    logic [7:0]         fifo [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               overflow;

    logic               in_avail;
    logic [7:0]         in_reg;
    logic [7:0]         status;

    // Phase edges: each phi2 edge produces exactly one single-clk strobe
    assign rise      = clk2 & ~clk2_q;
    assign fall      = ~clk2 & clk2_q;
    assign in_ram    = (addr >> RAM_AW) == 16'd0;
    assign wr_commit = rise & ~rw;
    assign rd_commit = fall & rw;

    // Count MSB is set only when the FIFO holds exactly 2^FIFO_AW entries
    assign full      = count[FIFO_AW];
    assign out_valid = count != '0;
    assign out_data  = fifo[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push_req  = wr_commit & (addr == IO_FIFO);
    // A full FIFO still accepts a push when the host frees a slot this clk
    assign push_ok   = push_req & (~full | pop);

    assign in_ready  = ~in_avail;
    assign status    = {full, overflow, in_avail, 5'(count)};

    // Register phi2 to derive its edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) clk2_q <= 1'b0;
        else        clk2_q <= clk2;
    end

    // RAM store on the phi2 rise of a write cycle; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_commit && in_ram) mem[addr[RAM_AW-1:0]] <= odata;
    end

    // FIFO storage write; slot contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= odata;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (wr_commit && addr == IO_STAT)
                overflow <= 1'b0;
        end
    end

    // Inbound holding register: host loads when empty, CPU read at phi2 end empties it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_avail <= 1'b0;
            in_reg   <= 8'h00;
        end else if (in_valid && !in_avail) begin
            in_avail <= 1'b1;
            in_reg   <= in_data;
        end else if (rd_commit && addr == IO_IN) begin
            in_avail <= 1'b0;
        end
    end

    // Read data decode, purely combinational from the address
    always_comb begin
        idata = 8'hFF;
        if (in_ram)                  idata = mem[addr[RAM_AW-1:0]];
        else if (addr == 16'hFFFC)   idata = RESET_VEC[7:0];
        else if (addr == 16'hFFFD)   idata = RESET_VEC[15:8];
        else if (addr == IO_STAT)    idata = status;
        else if (addr == IO_IN)      idata = in_reg;
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_mem_responder
//  Description : Directed self-checking bench for bus_mem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  odata;
    logic        rw;
    logic        clk2;
    logic [7:0]  idata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    int tests = 0;
    int fails = 0;

    bus_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .odata     (odata),
        .rw        (rw),
        .clk2      (clk2),
        .idata     (idata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    always #5 clk = ~clk;

    // Full CPU store cycle with phi2 held high for several clks
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; odata = d; rw = 1'b0; clk2 = 1'b0;
        @(negedge clk); clk2 = 1'b1;
        repeat (3) @(negedge clk);
        clk2 = 1'b0;
        @(negedge clk); rw = 1'b1; addr = 16'hFFFC;
    endtask

    // Full CPU read cycle; data sampled late in phi2, side effect at its fall
    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk); addr = a; rw = 1'b1; clk2 = 1'b0;
        @(negedge clk); clk2 = 1'b1;
        repeat (2) @(negedge clk);
        d = idata;
        @(negedge clk); clk2 = 1'b0;
        @(negedge clk); addr = 16'hFFFC;
    endtask

    task automatic test_reset();
        reset = 1'b0; addr = 16'hFFFC; rw = 1'b1; clk2 = 1'b0; odata = 8'h00;
        out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (idata !== 8'h00) begin fails++; $display("FAIL vec_lo got %h exp 00", idata); end
        addr = 16'hFFFD; #1;
        tests++; if (idata !== 8'h02) begin fails++; $display("FAIL vec_hi got %h exp 02", idata); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_ram();
        logic [7:0] d;
        cpu_write(16'h0099, 8'h80);
        cpu_read(16'h0099, d);
        tests++; if (d !== 8'h80) begin fails++; $display("FAIL ram_0099 got %h exp 80", d); end
        cpu_read(16'h0899, d);
        tests++; if (d !== 8'hFF) begin fails++; $display("FAIL above_ram got %h exp FF", d); end
        cpu_write(16'h07FF, 8'h3C);
        cpu_read(16'h07FF, d);
        tests++; if (d !== 8'h3C) begin fails++; $display("FAIL ram_top got %h exp 3C", d); end
    endtask

    task automatic test_fifo_fill();
        logic [7:0] d;
        for (int i = 1; i <= 9; i++) begin
            cpu_write(16'hD000, 8'(i));
            if (i == 1) begin
                tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL first_push_valid got %b exp 1", out_valid); end
            end
            if (i == 8) begin
                cpu_read(16'hD001, d);
                tests++; if (d !== 8'h88) begin fails++; $display("FAIL status_full got %h exp 88", d); end
            end
        end
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'hC8) begin fails++; $display("FAIL status_ovf got %h exp C8", d); end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                fails++; $display("FAIL drain_%0d got v=%b %h exp v=1 %h", i, out_valid, out_data, 8'(i)); end
            out_ready = 1'b1;
            @(negedge clk); out_ready = 1'b0;
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drained_valid got %b exp 0", out_valid); end
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'h40) begin fails++; $display("FAIL status_empty_ovf got %h exp 40", d); end
        cpu_write(16'hD001, 8'h00);
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL ovf_clear got %h exp 00", d); end
    endtask

    task automatic test_full_pop();
        logic [7:0] d;
        logic [7:0] exp_q [8];
        for (int i = 0; i < 8; i++) cpu_write(16'hD000, 8'(8'h11 + i));
        @(negedge clk); addr = 16'hD000; odata = 8'hAA; rw = 1'b0; clk2 = 1'b0;
        @(negedge clk); clk2 = 1'b1; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        repeat (2) @(negedge clk);
        clk2 = 1'b0;
        @(negedge clk); rw = 1'b1; addr = 16'hFFFC;
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'h88) begin fails++; $display("FAIL full_pop_status got %h exp 88", d); end
        for (int i = 0; i < 7; i++) exp_q[i] = 8'(8'h12 + i);
        exp_q[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                fails++; $display("FAIL full_pop_drain_%0d got v=%b %h exp v=1 %h", i, out_valid, out_data, exp_q[i]); end
            out_ready = 1'b1;
            @(negedge clk); out_ready = 1'b0;
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_pop_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_inbound();
        logic [7:0] d;
        @(negedge clk); in_data = 8'h5A; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_data = 8'h00;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL in_ready_low got %b exp 0", in_ready); end
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'h20) begin fails++; $display("FAIL in_avail_status got %h exp 20", d); end
        cpu_read(16'hD002, d);
        tests++; if (d !== 8'h5A) begin fails++; $display("FAIL in_read got %h exp 5A", d); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL in_ready_back got %b exp 1", in_ready); end
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL in_cleared_status got %h exp 00", d); end
        cpu_read(16'hD002, d);
        tests++; if (d !== 8'h5A) begin fails++; $display("FAIL in_stale got %h exp 5A", d); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        cpu_write(16'h0055, 8'hC3);
        for (int i = 0; i < 3; i++) cpu_write(16'hD000, 8'(8'h30 + i));
        @(negedge clk); in_data = 8'h77; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'h23) begin fails++; $display("FAIL pre_reset_status got %h exp 23", d); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
        cpu_read(16'hD001, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL mid_rst_status got %h exp 00", d); end
        cpu_read(16'hD002, d);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL mid_rst_inreg got %h exp 00", d); end
        cpu_read(16'h0055, d);
        tests++; if (d !== 8'hC3) begin fails++; $display("FAIL ram_kept_0055 got %h exp C3", d); end
        cpu_read(16'h0099, d);
        tests++; if (d !== 8'h80) begin fails++; $display("FAIL ram_kept_0099 got %h exp 80", d); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_fill();
        test_full_pop();
        test_inbound();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
